// File: rtl/nibble_link_host.sv
// Host-side bridge for the Nibbler CPU nibble ports: a byte FIFO feeds the CPU
// one nibble per toggle handshake, and CPU nibble pairs are packed into bytes.
module nibble_link_host #(
  parameter int N     = 4,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   tx_data,
  input  logic         tx_valid,
  output logic         tx_ready,
  output logic [7:0]   rx_data,
  output logic         rx_valid,
  input  logic         rx_ready,
  input  logic [N-1:0] Out0,
  input  logic [N-1:0] Out1,
  output logic [N-1:0] In0,
  output logic [N-1:0] In1,
  output logic [N-1:0] In2
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {D_IDLE, D_HI, D_LO} down_state_e;
  typedef enum logic {U_HI, U_LO} up_state_e;

  logic [7:0]   mem_q [DEPTH];
  logic [AW:0]  wptr_q, rptr_q, wptr_d, rptr_d;
  logic         fifo_full, fifo_empty, push, pop;
  logic [7:0]   fifo_head;

  logic [1:0]   sync1_q, sync2_q;
  logic         ack_sync, up_sync;

  down_state_e  dstate_q;
  logic [N-1:0] in0_q;
  logic [3:0]   lo_q;
  logic         tog_q, phase_q;

  up_state_e    ustate_q;
  logic [3:0]   hi_q;
  logic         uack_q;
  logic [7:0]   rx_data_q;
  logic         rx_valid_q;
  logic         up_edge;
  logic         unused_out1;

  assign unused_out1 = ^Out1[N-1:2];

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign tx_ready   = !fifo_full;
  assign push       = tx_valid && !fifo_full;
  assign pop        = (dstate_q == D_IDLE) && !fifo_empty;
  assign fifo_head  = mem_q[rptr_q[AW-1:0]];
  assign wptr_d     = wptr_q + {{AW{1'b0}}, push};
  assign rptr_d     = rptr_q + {{AW{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= tx_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      sync1_q <= Out1[1:0];
      sync2_q <= sync1_q;
    end
  end

  assign ack_sync = sync2_q[0];
  assign up_sync  = sync2_q[1];

  // A nibble is pending for the CPU while our toggle differs from its ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dstate_q <= D_IDLE;
      in0_q    <= '0;
      lo_q     <= '0;
      tog_q    <= 1'b0;
      phase_q  <= 1'b0;
    end else begin
      case (dstate_q)
        D_IDLE: if (!fifo_empty) begin
          in0_q    <= fifo_head[7:4];
          lo_q     <= fifo_head[3:0];
          phase_q  <= 1'b1;
          tog_q    <= ~tog_q;
          dstate_q <= D_HI;
        end
        D_HI: if (ack_sync == tog_q) begin
          in0_q    <= lo_q;
          phase_q  <= 1'b0;
          tog_q    <= ~tog_q;
          dstate_q <= D_LO;
        end
        D_LO: if (ack_sync == tog_q) dstate_q <= D_IDLE;
        default: dstate_q <= D_IDLE;
      endcase
    end
  end

  assign up_edge = (up_sync != uack_q);

  // Withholding the low-nibble ack is the only backpressure the CPU sees.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ustate_q   <= U_HI;
      hi_q       <= '0;
      uack_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;
      case (ustate_q)
        U_HI: if (up_edge) begin
          hi_q     <= Out0[3:0];
          uack_q   <= up_sync;
          ustate_q <= U_LO;
        end
        U_LO: if (up_edge && (!rx_valid_q || rx_ready)) begin
          rx_data_q  <= {hi_q, Out0[3:0]};
          rx_valid_q <= 1'b1;
          uack_q     <= up_sync;
          ustate_q   <= U_HI;
        end
        default: ustate_q <= U_HI;
      endcase
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign In0      = in0_q;
  assign In1      = {1'b0, uack_q, phase_q, tog_q};
  assign In2      = {2'b00, rx_valid_q, !fifo_empty || (dstate_q != D_IDLE)};

endmodule

// File: tb/tb_nibble_link_host.sv
// Self-checking bench for nibble_link_host: a CPU-side model drives the toggle
// handshakes while byte-level scoreboards check both directions every cycle.
module tb_nibble_link_host;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [3:0] cpuOut0 = '0;
  logic       cpuAck = 1'b0;
  logic       cpuUp = 1'b0;
  logic [3:0] Out1;
  logic [3:0] In0, In1, In2;

  assign Out1 = {2'b00, cpuUp, cpuAck};

  nibble_link_host #(.N(4), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .Out0(cpuOut0), .Out1(Out1),
    .In0(In0), .In1(In1), .In2(In2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] downExp[$];
  logic [7:0] upExp[$];
  int         occ = 0;
  int         downDone = 0;
  logic [3:0] curLo = '0;
  logic       prevTog = 1'b0;
  bit         ackEnable = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Host-side transactions: accepted pushes enter the down model, consumed bytes leave the up model.
  always @(posedge clk) begin
    if (!reset) begin
      if (tx_valid && tx_ready) begin
        downExp.push_back(tx_data);
        occ++;
      end
      if (rx_valid && rx_ready) begin
        if (upExp.size() == 0) checkOutput("rx_extra_byte", 1, 0);
        else checkOutput("rx_data", rx_data, upExp.pop_front());
      end
    end
  end

  // Every cycle: each new down nibble must match the next queued byte, and status must agree with occupancy.
  always @(negedge clk) begin
    logic [7:0] b;
    if (reset) begin
      downExp.delete();
      occ = 0;
      prevTog = 1'b0;
    end else begin
      if (In1[0] != prevTog) begin
        if (In1[1]) begin
          if (downExp.size() == 0) checkOutput("down_extra_byte", 1, 0);
          else begin
            b = downExp.pop_front();
            checkOutput("down_hi_nibble", In0, b[7:4]);
            curLo = b[3:0];
            occ--;
          end
        end else begin
          checkOutput("down_lo_nibble", In0, curLo);
          downDone++;
        end
        prevTog = In1[0];
      end
      checkOutput("tx_ready", tx_ready, occ < DEPTH);
      checkOutput("in2_rx_valid", In2[1], rx_valid);
      checkOutput("in_reserved", {In1[3], In2[3:2]}, 0);
    end
  end

  // CPU model for the down path: acknowledge any pending nibble when enabled.
  always @(negedge clk) begin
    if (ackEnable && !reset && In1[0] != cpuAck) cpuAck = In1[0];
  end

  // Push one host byte, waiting (bounded) for space; called at posedge+1.
  task automatic applyStimulus(input logic [7:0] b);
    int n = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!tx_ready) checkOutput("push_timeout", 1, 0);
    else begin
      @(posedge clk); #1;
    end
    tx_valid = 1'b0;
  endtask

  task automatic cpuSendNibble(input logic [3:0] n, input int limit, output bit acked, output int lat);
    int k = 0;
    cpuOut0 = n;
    @(posedge clk); #1;
    cpuUp = ~cpuUp;
    while (In1[2] != cpuUp && k < limit) begin
      @(posedge clk); #1;
      k++;
    end
    acked = (In1[2] == cpuUp);
    lat = k;
  endtask

  task automatic cpuSendByte(input logic [7:0] b);
    bit acked;
    int lat;
    upExp.push_back(b);
    cpuSendNibble(b[7:4], 20, acked, lat);
    checkOutput("up_hi_ack", acked, 1);
    cpuSendNibble(b[3:0], 50, acked, lat);
    checkOutput("up_lo_ack", acked, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  k;
    int  lat;
    int  target;
    bit  acked;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("rst_in0", In0, 0);
    checkOutput("rst_in1", In1, 0);
    checkOutput("rst_in2", In2, 0);
    checkOutput("rst_tx_ready", tx_ready, 1);
    checkOutput("rst_rx_valid", rx_valid, 0);
    checkOutput("rst_rx_data", rx_data, 0);
    @(posedge clk); #1;

    // Single down byte 0xA5 with hand-driven acks
    applyStimulus(8'hA5);
    k = 0;
    while (In1[0] !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
    checkOutput("dn_hi_in0", In0, 4'hA);
    checkOutput("dn_hi_in1", In1, 4'b0011);
    checkOutput("dn_busy", In2[0], 1);
    @(negedge clk);
    cpuAck = In1[0];
    k = 0;
    do begin @(negedge clk); k++; end while (In1[0] == cpuAck && k < 10);
    checkOutput("dn_ack_latency", k, 3);
    checkOutput("dn_lo_in0", In0, 4'h5);
    checkOutput("dn_lo_in1", In1, 4'b0000);
    @(negedge clk);
    cpuAck = In1[0];
    repeat (6) @(negedge clk);
    checkOutput("dn_idle_in2", In2[0], 0);
    checkOutput("dn_bytes_a5", downDone, 1);
    @(posedge clk); #1;

    // FIFO full: five accepted with no acks, sixth refused
    for (int i = 1; i <= 5; i++) applyStimulus(8'(i));
    checkOutput("full_tx_ready", tx_ready, 0);
    tx_data  = 8'h06;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    checkOutput("full_hold", tx_ready, 0);
    tx_valid = 1'b0;
    ackEnable = 1'b1;
    k = 0;
    while (downDone < 6 && k < 300) begin @(posedge clk); #1; k++; end
    checkOutput("full_bytes_out", downDone, 6);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("full_drained_in2", In2[0], 0);
    checkOutput("full_drained_ready", tx_ready, 1);

    // Reset during a down transfer and a half-received up byte
    ackEnable = 1'b0;
    cpuSendNibble(4'h4, 20, acked, lat);
    checkOutput("rstmid_up_hi_ack", acked, 1);
    applyStimulus(8'h77);
    k = 0;
    while (In1[0] == cpuAck && k < 20) begin @(posedge clk); #1; k++; end
    checkOutput("rstmid_pending_in0", In0, 4'h7);
    reset = 1'b1;
    #1;
    checkOutput("rstmid_in0", In0, 0);
    checkOutput("rstmid_in1", In1, 0);
    checkOutput("rstmid_in2", In2, 0);
    checkOutput("rstmid_tx_ready", tx_ready, 1);
    checkOutput("rstmid_rx_valid", rx_valid, 0);
    cpuAck  = 1'b0;
    cpuUp   = 1'b0;
    cpuOut0 = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // Up byte 0x3C with rx_ready low
    rx_ready = 1'b0;
    upExp.push_back(8'h3C);
    cpuSendNibble(4'h3, 10, acked, lat);
    checkOutput("up_hi_ack_3", acked, 1);
    checkOutput("up_ack_latency", lat, 3);
    cpuSendNibble(4'hC, 10, acked, lat);
    checkOutput("up_lo_ack_c", acked, 1);
    checkOutput("up_rx_valid", rx_valid, 1);
    checkOutput("up_rx_data", rx_data, 8'h3C);

    // Backpressure: second byte 0x96 while 0x3C still pending
    upExp.push_back(8'h96);
    cpuSendNibble(4'h9, 10, acked, lat);
    checkOutput("bp_hi_ack", acked, 1);
    cpuSendNibble(4'h6, 10, acked, lat);
    checkOutput("bp_lo_ack_held", acked, 0);
    checkOutput("bp_rx_data_kept", rx_data, 8'h3C);
    checkOutput("bp_rx_valid_kept", rx_valid, 1);
    rx_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_release_data", rx_data, 8'h96);
    checkOutput("bp_release_valid", rx_valid, 1);
    checkOutput("bp_release_ack", In1[2], cpuUp);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("bp_drained_valid", rx_valid, 0);
    checkOutput("bp_drained_queue", upExp.size(), 0);

    // Concurrent down 0x12,0x34 and up 0x56
    ackEnable = 1'b1;
    target = downDone + 2;
    fork
      begin
        applyStimulus(8'h12);
        applyStimulus(8'h34);
      end
      cpuSendByte(8'h56);
    join
    k = 0;
    while ((downDone < target || upExp.size() != 0) && k < 200) begin @(posedge clk); #1; k++; end
    checkOutput("conc_down_done", downDone, target);
    checkOutput("conc_up_done", upExp.size(), 0);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("conc_idle_in2", In2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
